// File: rtl/hub75_panel_capture_pkg.sv
// Shared HUB75 panel geometry, pixel type and colour constants.
// Also used by the drawing blocks that render menus, notes and scores.
package hub75_panel_capture_pkg;

  localparam int HUB_COLS      = 64;
  localparam int HUB_ROWS_HALF = 16;
  localparam int HUB_ROWS      = 32;

  typedef logic [2:0] pixel_t;  // {R,G,B}

  localparam pixel_t BLACK  = 3'b000;
  localparam pixel_t RED    = 3'b100;
  localparam pixel_t BLUE   = 3'b001;
  localparam pixel_t YELLOW = 3'b110;
  localparam pixel_t WHITE  = 3'b111;

endpackage

// File: rtl/hub75_edge_sync.sv
// Multi-stage synchronizer with an optional rising-edge detector on the
// synchronized value, so edges and co-sampled data stay aligned.
module hub75_edge_sync #(
  parameter int W        = 1,
  parameter int STAGES   = 2,
  parameter bit EDGE_DET = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic [W-1:0] prev_q;
      always_ff @(posedge clk) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= q_o;
      end
      assign rise_o = q_o & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/hub75_panel_capture.sv
// Receive-side HUB75 capture: oversamples the panel link, rebuilds the
// 32x64 frame store and reports row/frame status plus link error flags.
module hub75_panel_capture
  import hub75_panel_capture_pkg::*;
#(
  parameter int COLS        = HUB_COLS,
  parameter int ROWS_HALF   = HUB_ROWS_HALF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hub_clk,
  input  logic       hub_lat,
  input  logic       hub_oe,
  input  logic [3:0] hub_addr,
  input  logic [2:0] hub_rgb0,
  input  logic [2:0] hub_rgb1,
  input  logic [4:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [2:0] rd_pixel,
  output logic       row_latched,
  output logic [3:0] latched_row,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       len_err,
  output logic       oe_overlap
);

  localparam int CNT_W = $clog2(COLS + 1);
  localparam int IDX_W = $clog2(COLS);

  typedef pixel_t [COLS-1:0] row_t;

  logic        clk_rise, lat_rise;
  logic        clk_lvl_unused, lat_lvl_unused;
  logic [10:0] data_s, data_rise_unused;
  logic        oe_s;
  logic [3:0]  addr_s;
  pixel_t      rgb0_s, rgb1_s;

  hub75_edge_sync #(.W(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_clk_sync (
    .clk(clk), .rst(rst), .d_i(hub_clk), .q_o(clk_lvl_unused), .rise_o(clk_rise)
  );

  hub75_edge_sync #(.W(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_lat_sync (
    .clk(clk), .rst(rst), .d_i(hub_lat), .q_o(lat_lvl_unused), .rise_o(lat_rise)
  );

  // Same depth as the control lines so data is the value present at the edge.
  hub75_edge_sync #(.W(11), .STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_data_sync (
    .clk(clk), .rst(rst),
    .d_i({hub_oe, hub_addr, hub_rgb0, hub_rgb1}),
    .q_o(data_s), .rise_o(data_rise_unused)
  );

  assign {oe_s, addr_s, rgb0_s, rgb1_s} = data_s;

  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             overrun_q, overrun_d;
  row_t             up_buf_q, up_buf_d, lo_buf_q, lo_buf_d;
  logic [IDX_W-1:0] wr_idx;
  logic             shift_ok, commit_ok;
  logic [4:0]       up_row, lo_row;

  row_t             frame_q [2*ROWS_HALF];
  pixel_t           rd_pixel_q;
  logic             row_latched_q, frame_done_q, len_err_q, oe_overlap_q;
  logic [3:0]       latched_row_q;
  logic [7:0]       frame_count_q;

  assign wr_idx = shift_cnt_q[IDX_W-1:0];
  assign up_row = {1'b0, addr_s};
  assign lo_row = {1'b0, addr_s} + 5'(ROWS_HALF);

  // A shift coinciding with a latch lands in the buffer before the commit.
  always_comb begin
    up_buf_d    = up_buf_q;
    lo_buf_d    = lo_buf_q;
    shift_cnt_d = shift_cnt_q;
    overrun_d   = overrun_q;
    shift_ok    = clk_rise && (shift_cnt_q < CNT_W'(COLS));
    if (shift_ok) begin
      up_buf_d[wr_idx] = rgb0_s;
      lo_buf_d[wr_idx] = rgb1_s;
      shift_cnt_d      = shift_cnt_q + CNT_W'(1);
    end else if (clk_rise) begin
      overrun_d = 1'b1;
    end
    commit_ok = (shift_cnt_d == CNT_W'(COLS)) && !overrun_d;
    if (lat_rise) begin
      shift_cnt_d = '0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      up_buf_q      <= '0;
      lo_buf_q      <= '0;
      rd_pixel_q    <= '0;
      row_latched_q <= 1'b0;
      frame_done_q  <= 1'b0;
      latched_row_q <= '0;
      frame_count_q <= '0;
      len_err_q     <= 1'b0;
      oe_overlap_q  <= 1'b0;
      for (int r = 0; r < 2*ROWS_HALF; r++) frame_q[r] <= '0;
    end else begin
      shift_cnt_q   <= shift_cnt_d;
      overrun_q     <= overrun_d;
      up_buf_q      <= up_buf_d;
      lo_buf_q      <= lo_buf_d;
      row_latched_q <= lat_rise;
      frame_done_q  <= 1'b0;
      // Read uses pre-commit contents; a same-cycle commit shows next cycle.
      rd_pixel_q    <= frame_q[rd_row][rd_col];
      if (lat_rise) begin
        latched_row_q <= addr_s;
        if (commit_ok) begin
          frame_q[up_row] <= up_buf_d;
          frame_q[lo_row] <= lo_buf_d;
          if (addr_s == 4'(ROWS_HALF - 1)) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 8'd1;
          end
        end else begin
          len_err_q <= 1'b1;
        end
        if (!oe_s) oe_overlap_q <= 1'b1;
      end
    end
  end

  assign rd_pixel    = rd_pixel_q;
  assign row_latched = row_latched_q;
  assign latched_row = latched_row_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign len_err     = len_err_q;
  assign oe_overlap  = oe_overlap_q;

endmodule

// File: doc/hub75_panel_capture.md
Name: hub75_panel_capture

Overview:
- Receive-side model of the HUB75 panel link that the display driver transmits on.
- Oversamples the driver outputs (shift clock, LAT, OE, row address A-D, R0/G0/B0, R1/G1/B1) in the system clock domain.
- Reassembles the shifted pixels into a 32x64x3-bit frame store and exposes it through a read port plus frame/row status.
- Used as the bench-side and on-chip loopback checker for the game's menu, note and score rendering.

Parameters:
- COLS, 64, pixels shifted per row per half-panel.
- ROWS_HALF, 16, row addresses (A-D) per half-panel.
- SYNC_STAGES, 2, input synchronizer depth, minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the hub_clk rate.
- rst  in  1  synchronous reset, active-low.
- hub_clk  in  1  panel shift clock (driver's clk_shft).
- hub_lat  in  1  latch strobe.
- hub_oe  in  1  output enable, active-low.
- hub_addr  in  4  row address {D,C,B,A}.
- hub_rgb0  in  3  upper-half pixel {R0,G0,B0}.
- hub_rgb1  in  3  lower-half pixel {R1,G1,B1}.
- rd_row  in  5  frame-store read row, 0-31; 0-15 upper half, 16-31 lower half.
- rd_col  in  6  frame-store read column, 0-63.
- rd_pixel  out  3  {R,G,B} at (rd_row, rd_col); registered.
- row_latched  out  1  one-cycle pulse when a row is committed.
- latched_row  out  4  address of the last committed row.
- frame_done  out  1  one-cycle pulse when row 15 is committed.
- frame_count  out  8  number of completed frames; wraps 255->0.
- len_err  out  1  sticky; set when a latch arrives with a shift count other than COLS.
- oe_overlap  out  1  sticky; set when a latch rising edge is seen while hub_oe is low (panel lit).

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs are 0.
  - Shift counter is 0, the frame store is cleared to 0 and the synchronizers are cleared.
  - The clear completes in the reset cycle (register array, no sequential clear).
- Input sampling:
  - All hub_* inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized values.
  - Data, address and OE are sampled together with the detected edge, i.e. the values that were stable when hub_clk/hub_lat rose.
- Shift, on each hub_clk rising edge:
  - hub_rgb0 is written into the upper shift buffer at index shift_cnt.
  - hub_rgb1 is written into the lower shift buffer at index shift_cnt.
  - shift_cnt increments.
  - Column 0 is the first pixel shifted after a latch.
  - shift_cnt saturates at COLS; extra shifts beyond COLS are discarded and cause len_err at the next latch.
- Commit, on a hub_lat rising edge:
  - If shift_cnt == COLS: the upper buffer is copied to row hub_addr and the lower buffer to row hub_addr+16, in the same cycle.
  - If shift_cnt != COLS: nothing is written and len_err is set.
  - In both cases:
    - shift_cnt returns to 0.
    - row_latched pulses 1 cycle after the detected edge.
    - latched_row is updated.
  - If hub_addr == 15 and the commit was valid: frame_done pulses in the same cycle as row_latched, and frame_count increments.
- Simultaneous hub_clk and hub_lat edges in one sample: the shift is applied first, then the commit includes that pixel.
- OE check: a latch edge with hub_oe == 0 sets oe_overlap. It has no effect on data.
- Read port: rd_pixel is valid 1 clk after rd_row/rd_col.
- Read/write collision: a read of a row committed in the same cycle returns the old contents; the new data is visible from the next cycle.
- Sticky flags clear only on reset.
- Reset mid-row: any partial row is discarded; capture restarts from column 0 at the next shift edge.

Decomposition:
- Shared package holds:
  - HUB_COLS=64, HUB_ROWS_HALF=16, HUB_ROWS=32.
  - Pixel typedef (3-bit {R,G,B}).
  - Colour constants BLACK/RED/BLUE/YELLOW/WHITE, shared with the drawing blocks.
- One sub-module, hub75_edge_sync: the synchronizer plus rising-edge detector, instantiated once per control line (hub_clk, hub_lat) and as a plain synchronizer for the data, address and OE lines.

Test Plan:
- Row commit: after reset, shift 64 pixels with rgb0=3'b100 and rgb1=3'b001, then latch at addr=5 with OE high.
  - Rows 5 and 21 read 3'b100 and 3'b001 at all columns.
  - row_latched pulses once; latched_row=5; frame_done stays 0.
- Full frame: drive addr 0..15, each row with col-indexed data {col[2:0]}.
  - frame_done pulses exactly once, after addr 15; frame_count=1.
  - rd_row=18, rd_col=13 returns 3'b101.
- Short row: 63 shifts then a latch at addr=2.
  - len_err=1; row 2 is unchanged (0); the next 64-shift row at addr=3 commits normally.
- Long row: 70 shifts then a latch.
  - len_err=1; no write.
- OE overlap: latch while hub_oe=0.
  - oe_overlap=1; data is still committed.
- Reset mid-row: 30 shifts, pulse rst low, then 64 shifts and a latch at addr=0.
  - Row 0 is correct; len_err=0; frame store is otherwise 0.
- Wrap: 256 frames.
  - frame_count returns to 0.
